// File: rtl/router_sync_nport_pkg.sv
// Purpose: constants and helpers shared by the router synchroniser files.
// Latency: none. This file holds declarations only.
// Backpressure: none. This file holds declarations only.
// Contents: ROUTER_NUM_PORTS, ROUTER_SFT_TIMEOUT, addr_width().
package router_pkg;

  localparam int ROUTER_NUM_PORTS   = 3;
  localparam int ROUTER_SFT_TIMEOUT = 30;

  // The address register is never narrower than one bit, even for tiny port counts.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_nport_if.sv
// Purpose: groups the handshake, address and flag signals between the router FSM/FIFOs and the synchroniser.
// Latency: none. The interface holds wires only.
// Backpressure: FIFO full and empty flags pass through this interface. The interface itself does not stall.
// Ports: the slave modport is the synchroniser side, and the master modport is the FSM/FIFO side.
interface router_sync_nport_if
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int ADDR_W    = addr_width(NUM_PORTS)
);

  logic                 detect_addr;
  logic                 wr_enb_reg;
  logic [ADDR_W-1:0]    din;
  logic [NUM_PORTS-1:0] rd_enb;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] wr_enb;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] sft_rst;
  logic                 addr_err;

  modport slave (
    input  detect_addr, wr_enb_reg, din, rd_enb, empty, full,
    output wr_enb, fifo_full, vld_out, sft_rst, addr_err
  );

  modport master (
    output detect_addr, wr_enb_reg, din, rd_enb, empty, full,
    input  wr_enb, fifo_full, vld_out, sft_rst, addr_err
  );

endinterface

// File: rtl/router_sync_timer.sv
// Purpose: provides the stall timer for one output port and issues a one-cycle soft-reset pulse.
// Latency: the pulse rises on the TIMEOUT-th consecutive stalled edge.
// Backpressure: the reader's rd deassertion is the stall condition. The timer never stalls anything.
// Ports: clk, rstn (async active-low), vld (data waiting), rd (reader pops), sft_rst (pulse out).
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld,
  input  logic rd,
  output logic sft_rst
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sft_rst;
  logic             w_stall;

  assign w_stall = vld & ~rd;

  // The pulse cycle is handled first, so it never counts as a stalled edge.
  // As a result, back-to-back pulses are spaced TIMEOUT+1 edges apart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b0;
    end else if (r_sft_rst) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b0;
    end else if (!w_stall) begin
      r_cnt     <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt     <= '0;
      r_sft_rst <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign sft_rst = r_sft_rst;

endmodule

// File: rtl/router_sync_nport.sv
// Purpose: latches the packet address, steers the FIFO write enable, and raises per-port valid and timeout soft resets.
// Latency: the address is registered. Steering, fifo_full and vld_out are combinational from it.
// Backpressure: fifo_full reflects the addressed FIFO. Writes to an out-of-range address are dropped.
// Ports: clk, rstn (async active-low), and bus (router_sync_nport_if.slave).
module router_sync_nport
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int TIMEOUT   = ROUTER_SFT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rstn,
  router_sync_nport_if.slave     bus
);

  localparam int ADDR_W = addr_width(NUM_PORTS);
  localparam int CNT_W  = $clog2(TIMEOUT);

  logic [ADDR_W-1:0]    r_addr_q;
  logic                 r_addr_valid;
  logic                 r_addr_err;
  logic                 w_din_ok;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_sft_rst;

  // With a power-of-two port count, every din value is in range, so this reduces to constant 1.
  assign w_din_ok = (int'(bus.din) < NUM_PORTS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr_q     <= '0;
      r_addr_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (bus.detect_addr) begin
      r_addr_q     <= bus.din;
      r_addr_valid <= w_din_ok;
      r_addr_err   <= ~w_din_ok;
    end
  end

  // The select decode is one-hot or zero. An invalid latched address selects nothing.
  // That blocks writes and masks fifo_full without indexing past the full vector.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sel[i] = r_addr_valid & (int'(r_addr_q) == i);
    end
  end

  assign bus.wr_enb    = bus.wr_enb_reg ? w_sel : '0;
  assign bus.fifo_full = |(w_sel & bus.full);
  assign bus.addr_err  = r_addr_err;

  assign w_vld       = ~bus.empty;
  assign bus.vld_out = w_vld;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clk     (clk),
      .rstn    (rstn),
      .vld     (w_vld[g]),
      .rd      (bus.rd_enb[g]),
      .sft_rst (w_sft_rst[g])
    );
  end

  assign bus.sft_rst = w_sft_rst;

endmodule

// File: tb/tb_router_sync_nport.sv
// Purpose: bench for router_sync_nport. It covers a 3-port/30-cycle instance and a 4-port/5-cycle instance.
// Latency: inputs are driven on the falling edge. Outputs are checked 1 time unit after the rising edge.
// Backpressure: not applicable. Stall patterns come from the empty and rd_enb stimulus.
module tb_router_sync_nport;
  import router_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  router_sync_nport_if #(.NUM_PORTS(3)) ifa ();
  router_sync_nport_if #(.NUM_PORTS(4)) ifb ();

  router_sync_nport #(.NUM_PORTS(3), .TIMEOUT(30)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));
  router_sync_nport #(.NUM_PORTS(4), .TIMEOUT(5))  dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  // The reference model tracks, per instance, the latched address and the length of
  // the current stall run on each port. A port pulses when its run reaches TIMEOUT stalled edges.
  int np [2] = '{3, 4};
  int tmo[2] = '{30, 5};
  int m_addr [2];
  bit m_valid[2];
  bit m_err  [2];
  int m_run  [2][4];
  bit m_pulse[2][4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k]  = 0;
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_run[k][i]   = 0;
        m_pulse[k][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge(input int k, input bit det, input int din,
                            input logic [31:0] rd, input logic [31:0] empty);
    for (int i = 0; i < np[k]; i++) begin
      bit stall;
      stall = !empty[i] && !rd[i];
      if (m_pulse[k][i]) begin
        m_pulse[k][i] = 1'b0;
        m_run[k][i]   = 0;
      end else if (!stall) begin
        m_run[k][i] = 0;
      end else begin
        m_run[k][i]++;
        if (m_run[k][i] == tmo[k]) begin
          m_pulse[k][i] = 1'b1;
          m_run[k][i]   = 0;
        end
      end
    end
    if (det) begin
      m_addr[k]  = din;
      m_valid[k] = (din < np[k]);
      m_err[k]   = (din >= np[k]);
    end
  endtask

  task automatic check_inst(input int k, input string nm,
                            input logic [31:0] wr, input logic ff, input logic [31:0] vld,
                            input logic [31:0] sft, input logic err,
                            input bit wre, input logic [31:0] full, input logic [31:0] empty);
    logic [31:0] mask, exp_wr, exp_sft;
    logic        exp_ff;
    mask    = (32'd1 << np[k]) - 32'd1;
    exp_wr  = (wre && m_valid[k]) ? (32'd1 << m_addr[k]) : 32'd0;
    exp_ff  = m_valid[k] ? full[m_addr[k]] : 1'b0;
    exp_sft = 32'd0;
    for (int i = 0; i < np[k]; i++) exp_sft[i] = m_pulse[k][i];
    chk({nm, ".wr_enb"},    wr, exp_wr);
    chk({nm, ".fifo_full"}, {31'd0, ff}, {31'd0, exp_ff});
    chk({nm, ".vld_out"},   vld, ~empty & mask);
    chk({nm, ".sft_rst"},   sft, exp_sft);
    chk({nm, ".addr_err"},  {31'd0, err}, {31'd0, m_err[k]});
  endtask

  task automatic check_all();
    check_inst(0, "A", 32'(ifa.wr_enb), ifa.fifo_full, 32'(ifa.vld_out), 32'(ifa.sft_rst),
               ifa.addr_err, ifa.wr_enb_reg, 32'(ifa.full), 32'(ifa.empty));
    check_inst(1, "B", 32'(ifb.wr_enb), ifb.fifo_full, 32'(ifb.vld_out), 32'(ifb.sft_rst),
               ifb.addr_err, ifb.wr_enb_reg, 32'(ifb.full), 32'(ifb.empty));
  endtask

  // One rising edge: the model advances on the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      model_edge(0, ifa.detect_addr, int'(ifa.din), 32'(ifa.rd_enb), 32'(ifa.empty));
      model_edge(1, ifb.detect_addr, int'(ifb.din), 32'(ifb.rd_enb), 32'(ifb.empty));
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    ifa.detect_addr = 1'b0; ifa.wr_enb_reg = 1'b0; ifa.din = '0;
    ifa.rd_enb = '0; ifa.empty = '1; ifa.full = '0;
    ifb.detect_addr = 1'b0; ifb.wr_enb_reg = 1'b0; ifb.din = '0;
    ifb.rd_enb = '0; ifb.empty = '1; ifb.full = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check_all();
    chk("rst.wr_enb", 32'(ifa.wr_enb), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Latch address 2, then steer to port 2
    ifa.detect_addr = 1'b1; ifa.din = 2'd2;
    tick();
    ifa.detect_addr = 1'b0; ifa.wr_enb_reg = 1'b1; ifa.full = 3'b100;
    #1;
    chk("steer.wr_enb",    32'(ifa.wr_enb), 32'b100);
    chk("steer.fifo_full", {31'd0, ifa.fifo_full}, 32'd1);
    chk("steer.addr_err",  {31'd0, ifa.addr_err}, 32'd0);
    tick();

    // Out-of-range address 3 blocks writes and masks full
    ifa.wr_enb_reg = 1'b0; ifa.detect_addr = 1'b1; ifa.din = 2'd3;
    tick();
    ifa.detect_addr = 1'b0; ifa.wr_enb_reg = 1'b1; ifa.full = 3'b111;
    #1;
    chk("oor.addr_err",  {31'd0, ifa.addr_err}, 32'd1);
    chk("oor.wr_enb",    32'(ifa.wr_enb), 32'd0);
    chk("oor.fifo_full", {31'd0, ifa.fifo_full}, 32'd0);
    tick();
    ifa.wr_enb_reg = 1'b0; ifa.full = '0; ifa.detect_addr = 1'b1; ifa.din = 2'd0;
    tick();
    ifa.detect_addr = 1'b0;

    // Continuous stall on ports 0 and 2
    ifa.empty = 3'b010;
    repeat (29) tick();
    chk("stall.e29", 32'(ifa.sft_rst), 32'd0);
    tick();
    chk("stall.e30", 32'(ifa.sft_rst), 32'b101);
    tick();
    chk("stall.e31", 32'(ifa.sft_rst), 32'd0);
    repeat (29) tick();
    chk("stall.e60", 32'(ifa.sft_rst), 32'd0);
    tick();
    chk("stall.e61", 32'(ifa.sft_rst), 32'b101);
    ifa.empty = 3'b111;
    tick();

    // A single read on port 0 at edge 20 restarts that port's count
    ifa.empty = 3'b010;
    repeat (19) tick();
    ifa.rd_enb = 3'b001;
    tick();
    ifa.rd_enb = 3'b000;
    repeat (9) tick();
    tick();
    chk("read.e30", 32'(ifa.sft_rst), 32'b100);
    repeat (19) tick();
    tick();
    chk("read.e50", 32'(ifa.sft_rst), 32'b001);
    ifa.empty = 3'b111;
    tick();

    // Reset in the middle of a count
    ifa.empty = 3'b010; ifa.wr_enb_reg = 1'b1;
    repeat (25) tick();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("mrst.sft_rst", 32'(ifa.sft_rst), 32'd0);
    chk("mrst.wr_enb",  32'(ifa.wr_enb), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    chk("mrst.rel.wr_enb", 32'(ifa.wr_enb), 32'd0);
    repeat (29) tick();
    chk("mrst.e29", 32'(ifa.sft_rst), 32'd0);
    tick();
    chk("mrst.e30", 32'(ifa.sft_rst), 32'b101);
    ifa.wr_enb_reg = 1'b0; ifa.empty = 3'b111;
    tick();

    // 4-port instance: address 3 valid, port 1 stall pulses at the 5th edge
    ifb.detect_addr = 1'b1; ifb.din = 2'd3; ifb.wr_enb_reg = 1'b1; ifb.empty = 4'b1101;
    tick();
    chk("b.wr_enb",   32'(ifb.wr_enb), 32'b1000);
    chk("b.addr_err", {31'd0, ifb.addr_err}, 32'd0);
    repeat (3) tick();
    chk("b.e4", 32'(ifb.sft_rst), 32'd0);
    tick();
    chk("b.e5", 32'(ifb.sft_rst), 32'b0010);
    ifb.detect_addr = 1'b0; ifb.wr_enb_reg = 1'b0; ifb.empty = 4'b1111;
    tick();

    // Randomized traffic on both instances
    repeat (1500) begin
      ifa.detect_addr = ($urandom_range(0, 7) == 0);
      ifa.din         = 2'($urandom_range(0, 3));
      ifa.wr_enb_reg  = 1'($urandom_range(0, 1));
      ifa.full        = 3'($urandom_range(0, 7));
      ifb.detect_addr = ($urandom_range(0, 7) == 0);
      ifb.din         = 2'($urandom_range(0, 3));
      ifb.wr_enb_reg  = 1'($urandom_range(0, 1));
      ifb.full        = 4'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 49) == 0) ifa.empty[i] = ~ifa.empty[i];
        ifa.rd_enb[i] = ($urandom_range(0, 39) == 0);
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) ifb.empty[i] = ~ifb.empty[i];
        ifb.rd_enb[i] = ($urandom_range(0, 5) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_sync_nport.md
Name: router_sync_nport

Overview:
Parametrised successor to the 1x3 router synchroniser. It latches the destination address of each packet and steers the write enable to one of NUM_PORTS output FIFOs. It generates per-port valid-out from FIFO empty flags and issues a per-port one-cycle soft reset when a port's valid data sits unread for TIMEOUT consecutive cycles. It sits between the router FSM/register block and the NUM_PORTS output FIFOs, and adds detection of out-of-range addresses.

Parameters:
- NUM_PORTS, 3, number of output ports/FIFOs; legal range 2..16.
- TIMEOUT, 30, consecutive unread-valid cycles before a port's soft reset; legal minimum 2.
- ADDR_W, $clog2(NUM_PORTS), derived localparam; width of din and of the address register.
- CNT_W, $clog2(TIMEOUT), derived localparam; timeout counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- detect_addr  in  1  FSM strobe: din carries the header address this cycle.
- wr_enb_reg  in  1  FSM write request for the current packet byte.
- din  in  ADDR_W  destination port address.
- rd_enb  in  NUM_PORTS  per-port read enable from the downstream reader.
- empty  in  NUM_PORTS  per-port FIFO empty flag.
- full  in  NUM_PORTS  per-port FIFO full flag.
- wr_enb  out  NUM_PORTS  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out  out  NUM_PORTS  per-port valid data available.
- sft_rst  out  NUM_PORTS  per-port one-cycle soft-reset pulse.
- addr_err  out  1  last latched address was out of range.

Behaviour:
Reset (rstn=0, asynchronous):
- addr_q=0, addr_valid=0, addr_err=0.
- All timeout counters 0; sft_rst=0.
- Combinational outputs follow from the cleared registers: wr_enb=0, fifo_full=0.
- vld_out follows empty and is independent of reset.
- A reset mid-packet or mid-count takes effect immediately, with no pending pulse.

Address latch:
- On each rising edge with detect_addr=1: addr_q<=din; addr_valid<=(din<NUM_PORTS); addr_err<=(din>=NUM_PORTS).
- These values hold until the next detect_addr.
- With NUM_PORTS a power of two, addr_err is constant 0.

Write steering (combinational from registers):
- wr_enb[i] = wr_enb_reg & addr_valid & (addr_q==i). At most one bit is set.
- When detect_addr and wr_enb_reg are both high in the same cycle, the previously latched address steers.
- fifo_full = addr_valid ? full[addr_q] : 0.
- An invalid address blocks all writes; the bytes are dropped.

Valid out:
- vld_out[i] = ~empty[i], combinational, zero latency.

Timeout, independently per port i:
- stall_i = vld_out[i] & ~rd_enb[i].
- When sft_rst[i]=1: cnt_i<=0 and sft_rst[i]<=0. The pulse cycle never counts.
- Otherwise, when stall_i=0: cnt_i<=0.
- Otherwise, when cnt_i==TIMEOUT-1: cnt_i<=0 and sft_rst[i]<=1.
- Otherwise: cnt_i<=cnt_i+1.
- sft_rst[i] therefore rises at the TIMEOUT-th consecutive stalled edge and lasts exactly one cycle.
- If the stall continues, the next pulse comes TIMEOUT+1 edges after the previous one.
- A single rd_enb cycle, or empty going high, clears the count.
- Ports are fully independent; simultaneous pulses on several ports are allowed.
- The counter never wraps and never exceeds TIMEOUT-1.

Decomposition:
- Shared package router_pkg: default constants ROUTER_NUM_PORTS=3 and ROUTER_SFT_TIMEOUT=30, plus an addr_width(n) function used for ADDR_W.
- Sub-module router_sync_timer (parameters TIMEOUT, CNT_W; ports clk, rstn, vld, rd, sft_rst) holds one port's counter and pulse register.
- router_sync_timer is instantiated NUM_PORTS times via a generate loop.
- Address latch and steering remain in the top level.

Test Plan:
- Default parameters; reset, detect_addr=1 with din=2, then wr_enb_reg=1 -> wr_enb=3'b100; with full=3'b100, fifo_full=1 and addr_err=0.
- NUM_PORTS=3; detect_addr with din=3, then wr_enb_reg=1 -> addr_err=1, wr_enb=0, fifo_full=0 even with full=3'b111.
- empty=3'b010 and rd_enb=0 held for 29 edges -> sft_rst=0; after the 30th edge sft_rst=3'b101 for one cycle; the next pulse comes 31 edges later.
- Same stall, but rd_enb[0]=1 for one cycle at edge 20 -> port 0 pulses 30 edges after that read; port 2 still pulses at edge 30.
- rstn asserted at stall edge 25, released 2 cycles later -> sft_rst stays 0, counts restart from 0, and addr_q/addr_valid are cleared so wr_enb=0.
- NUM_PORTS=4, TIMEOUT=5; din=3 with detect_addr and wr_enb_reg held -> wr_enb=4'b1000, addr_err=0; port 1 stalled -> sft_rst[1] pulses at the 5th edge.
